// File: rtl/tt_pkg.sv
// Shared types and sizing helpers for the truth-table sweeper.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_N_IN = 3;
    localparam int ROWS     = 2 ** DEF_N_IN;

    function automatic int rows_for(input int n_in);
        return 2 ** n_in;
    endfunction

endpackage

// File: rtl/sweep_counter.sv
// Row index counter for a sweep: synchronous clear, saturating increment, terminal flag.
module sweep_counter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [N-1:0] idx,
    output logic         last
);

    logic [N-1:0] idx_q;
    logic [N-1:0] idx_d;

    // terminal row is checked before incrementing so the index never wraps inside a sweep
    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (inc && !last) begin
            idx_d = idx_q + N'(1);
        end else begin
            idx_d = idx_q;
        end
    end

    // index register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx  = idx_q;
    assign last = &idx_q;

endmodule

// File: rtl/truth_table_sweeper.sv
// Streams every (row, f(row)) pair of a stored truth table under valid/ready,
// then pulses done and reports how many rows evaluated to 1.
module truth_table_sweeper
    import tt_pkg::*;
#(
    parameter int                     N_IN  = 3,
    parameter logic [(2**N_IN)-1:0]   TABLE = 8'h8A
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     tbl_load,
    input  logic [(2**N_IN)-1:0]     tbl_in,
    output logic                     busy,
    output logic                     row_valid,
    input  logic                     row_ready,
    output logic [N_IN-1:0]          row_in,
    output logic                     row_out,
    output logic                     done,
    output logic [N_IN:0]            ones_count
);

    localparam int NUM_ROWS = rows_for(N_IN);
    localparam int CW       = N_IN + 1;

    state_t                state_q;
    state_t                state_d;
    logic [NUM_ROWS-1:0]   tbl_q;
    logic [NUM_ROWS-1:0]   tbl_d;
    logic [CW-1:0]         ones_q;
    logic [CW-1:0]         ones_d;
    logic                  row_valid_q;
    logic                  row_valid_d;
    logic                  row_out_q;
    logic                  row_out_d;
    logic                  done_q;
    logic                  done_d;
    logic                  busy_q;
    logic                  busy_d;

    logic [N_IN-1:0]       idx_s;
    logic [N_IN-1:0]       idx_next_s;
    logic                  last_s;
    logic                  clr_s;
    logic                  inc_s;
    logic                  xfer_s;

    sweep_counter #(
        .N (N_IN)
    ) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_s),
        .inc   (inc_s),
        .idx   (idx_s),
        .last  (last_s)
    );

    assign xfer_s = (state_q == SWEEP) && row_valid_q && row_ready;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SWEEP;
                end else begin
                    state_d = IDLE;
                end
            end
            SWEEP: begin
                if (xfer_s && last_s) begin
                    state_d = DONE;
                end else begin
                    state_d = SWEEP;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // datapath and output next values; a load in IDLE lands before a same-cycle start
    always_comb begin
        tbl_d = tbl_q;
        if ((state_q == IDLE) && tbl_load) begin
            tbl_d = tbl_in;
        end else begin
            tbl_d = tbl_q;
        end

        clr_s = (state_q == IDLE) && start;
        inc_s = xfer_s && !last_s;

        ones_d = ones_q;
        if (clr_s) begin
            ones_d = '0;
        end else if (xfer_s) begin
            ones_d = ones_q + CW'(row_out_q);
        end else begin
            ones_d = ones_q;
        end

        idx_next_s = idx_s;
        if (clr_s) begin
            idx_next_s = '0;
        end else if (inc_s) begin
            idx_next_s = idx_s + N_IN'(1);
        end else begin
            idx_next_s = idx_s;
        end

        row_out_d   = tbl_d[idx_next_s];
        row_valid_d = (state_d == SWEEP);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    // table, accumulator and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl_q       <= TABLE;
            ones_q      <= '0;
            row_valid_q <= 1'b0;
            row_out_q   <= TABLE[0];
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            tbl_q       <= tbl_d;
            ones_q      <= ones_d;
            row_valid_q <= row_valid_d;
            row_out_q   <= row_out_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign busy       = busy_q;
    assign row_valid  = row_valid_q;
    assign row_in     = idx_s;
    assign row_out    = row_out_q;
    assign done       = done_q;
    assign ones_count = ones_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench: a list-of-rows model of the table drives expectations for
// both the default 3-input instance and a 1-input instance.
module tb_truth_table_sweeper;

    logic       clk    = 1'b0;
    logic       clk_en = 1'b1;
    logic       rst_n  = 1'b0;

    logic       start     = 1'b0;
    logic       tbl_load  = 1'b0;
    logic [7:0] tbl_in    = 8'h00;
    logic       row_ready = 1'b0;
    logic       busy, row_valid, row_out, done;
    logic [2:0] row_in;
    logic [3:0] ones_count;

    logic       start1     = 1'b0;
    logic       tbl_load1  = 1'b0;
    logic [1:0] tbl_in1    = 2'b00;
    logic       row_ready1 = 1'b0;
    logic       busy1, row_valid1, row_out1, done1;
    logic [0:0] row_in1;
    logic [1:0] ones1;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] model_tbl = 8'h8A;

    always #5 if (clk_en) clk = ~clk;

    truth_table_sweeper #(.N_IN(3), .TABLE(8'h8A)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .tbl_load   (tbl_load),
        .tbl_in     (tbl_in),
        .busy       (busy),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .row_in     (row_in),
        .row_out    (row_out),
        .done       (done),
        .ones_count (ones_count)
    );

    truth_table_sweeper #(.N_IN(1), .TABLE(2'b10)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start1),
        .tbl_load   (tbl_load1),
        .tbl_in     (tbl_in1),
        .busy       (busy1),
        .row_valid  (row_valid1),
        .row_ready  (row_ready1),
        .row_in     (row_in1),
        .row_out    (row_out1),
        .done       (done1),
        .ones_count (ones1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_table(input logic [7:0] v);
        tbl_in   = v;
        tbl_load = 1'b1;
        step();
        tbl_load  = 1'b0;
        model_tbl = v;
        tests++;
        if (busy !== 1'b0 || row_valid !== 1'b0) begin
            fails++;
            $display("FAIL load_idle: busy=%b valid=%b, required 0 0", busy, row_valid);
        end
    endtask

    // mode 0: always ready, 1: stall first cycle of rows 3 and 6, 2: random ready,
    // 3: always ready plus start/tbl_load=00 injected at row 4 (must be ignored)
    task automatic run_sweep(input int mode, input logic do_load, input logic [7:0] load_val);
        int   exp_idx;
        int   cyc;
        int   stalls;
        int   done_at;
        int   ones_model;
        logic rdy;
        logic st3;
        logic st6;
        logic inj;
        exp_idx = 0; stalls = 0; done_at = -1; ones_model = 0;
        st3 = 1'b0; st6 = 1'b0; inj = 1'b0; rdy = 1'b1;
        if (do_load) begin
            tbl_load  = 1'b1;
            tbl_in    = load_val;
            model_tbl = load_val;
        end
        start = 1'b1;
        step();
        start    = 1'b0;
        tbl_load = 1'b0;
        cyc      = 1;
        while (cyc < 80) begin
            if (done) begin
                done_at = cyc;
                break;
            end
            tests++;
            if (exp_idx > 7) begin
                fails++;
                $display("FAIL extra_row: row %0d offered, only 8 rows exist", row_in);
                break;
            end
            if (row_valid !== 1'b1 || busy !== 1'b1 || row_in !== exp_idx[2:0] ||
                row_out !== model_tbl[exp_idx]) begin
                fails++;
                $display("FAIL row_stream: cyc=%0d got valid=%b busy=%b row=%0d out=%b, required 1 1 %0d %b",
                         cyc, row_valid, busy, row_in, row_out, exp_idx, model_tbl[exp_idx]);
            end
            case (mode)
                1: begin
                    if (exp_idx == 3 && !st3) begin
                        rdy = 1'b0; st3 = 1'b1;
                    end else if (exp_idx == 6 && !st6) begin
                        rdy = 1'b0; st6 = 1'b1;
                    end else begin
                        rdy = 1'b1;
                    end
                end
                2: rdy = 1'($urandom_range(0, 1));
                3: begin
                    rdy = 1'b1;
                    if (exp_idx == 4 && !inj) begin
                        start = 1'b1; tbl_load = 1'b1; tbl_in = 8'h00; inj = 1'b1;
                    end
                end
                default: rdy = 1'b1;
            endcase
            row_ready = rdy;
            if (rdy) begin
                ones_model += int'(model_tbl[exp_idx]);
                exp_idx++;
            end else begin
                stalls++;
            end
            step();
            start    = 1'b0;
            tbl_load = 1'b0;
            cyc++;
        end
        row_ready = 1'b0;
        tests++;
        if (done_at != 9 + stalls) begin
            fails++;
            $display("FAIL done_cycle: done seen at cycle %0d, required %0d", done_at, 9 + stalls);
        end
        tests++;
        if (exp_idx != 8) begin
            fails++;
            $display("FAIL rows_sent: %0d rows accepted, required 8", exp_idx);
        end
        tests++;
        if (ones_count !== 4'(ones_model) || row_valid !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL done_state: ones=%0d valid=%b busy=%b, required %0d 0 1",
                     ones_count, row_valid, busy, ones_model);
        end
        step();
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || row_valid !== 1'b0 || ones_count !== 4'(ones_model)) begin
            fails++;
            $display("FAIL after_done: done=%b busy=%b valid=%b ones=%0d, required 0 0 0 %0d",
                     done, busy, row_valid, ones_count, ones_model);
        end
    endtask

    task automatic test_reset();
        #12;
        tests++;
        if (busy !== 1'b0 || row_valid !== 1'b0 || done !== 1'b0 || row_in !== 3'd0 ||
            row_out !== 1'b0 || ones_count !== 4'd0) begin
            fails++;
            $display("FAIL reset3: busy=%b valid=%b done=%b row=%0d out=%b ones=%0d, required 0 0 0 0 0 0",
                     busy, row_valid, done, row_in, row_out, ones_count);
        end
        tests++;
        if (busy1 !== 1'b0 || row_valid1 !== 1'b0 || row_out1 !== 1'b0 || ones1 !== 2'd0) begin
            fails++;
            $display("FAIL reset1: busy=%b valid=%b out=%b ones=%0d, required 0 0 0 0",
                     busy1, row_valid1, row_out1, ones1);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_default();
        run_sweep(0, 1'b0, 8'h00);
        tests++;
        if (ones_count !== 4'd3) begin
            fails++;
            $display("FAIL default_ones: got %0d, required 3", ones_count);
        end
    endtask

    task automatic test_backpressure();
        run_sweep(1, 1'b0, 8'h00);
        tests++;
        if (ones_count !== 4'd3) begin
            fails++;
            $display("FAIL bp_ones: got %0d, required 3", ones_count);
        end
    endtask

    task automatic test_table_load();
        load_table(8'hFF);
        run_sweep(0, 1'b0, 8'h00);
        tests++;
        if (ones_count !== 4'd8) begin
            fails++;
            $display("FAIL load_ff_ones: got %0d, required 8", ones_count);
        end
        load_table(8'h00);
        run_sweep(0, 1'b0, 8'h00);
        tests++;
        if (ones_count !== 4'd0) begin
            fails++;
            $display("FAIL load_00_ones: got %0d, required 0", ones_count);
        end
    endtask

    task automatic test_ignore_in_sweep();
        load_table(8'h8A);
        run_sweep(3, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL ignore_in_sweep: done=%b busy=%b after sweep, required 0 0", done, busy);
            end
        end
    endtask

    task automatic test_start_with_load();
        run_sweep(0, 1'b1, 8'h01);
        tests++;
        if (ones_count !== 4'd1) begin
            fails++;
            $display("FAIL start_load_ones: got %0d, required 1", ones_count);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 5; n++) begin
            load_table(8'($urandom()));
            run_sweep(2, 1'b0, 8'h00);
        end
    endtask

    task automatic test_reset_mid_sweep();
        load_table(8'hFF);
        start = 1'b1;
        step();
        start     = 1'b0;
        row_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (row_in == 3'd5) break;
            step();
        end
        clk_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_tbl = 8'h8A;
        tests++;
        if (busy !== 1'b0 || row_valid !== 1'b0 || done !== 1'b0 || row_in !== 3'd0 ||
            row_out !== 1'b0 || ones_count !== 4'd0) begin
            fails++;
            $display("FAIL mid_reset: busy=%b valid=%b done=%b row=%0d out=%b ones=%0d, required 0 0 0 0 0 0",
                     busy, row_valid, done, row_in, row_out, ones_count);
        end
        #3;
        rst_n = 1'b1;
        row_ready = 1'b0;
        #2;
        clk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL mid_reset_idle: done=%b busy=%b, required 0 0", done, busy);
            end
        end
        run_sweep(0, 1'b0, 8'h00);
        tests++;
        if (ones_count !== 4'd3) begin
            fails++;
            $display("FAIL mid_reset_resweep_ones: got %0d, required 3", ones_count);
        end
    endtask

    task automatic test_n1();
        logic [1:0] tbl1;
        int         exp_idx;
        int         cyc;
        int         ones_model;
        tbl1 = 2'b10; exp_idx = 0; ones_model = 0;
        start1 = 1'b1;
        step();
        start1     = 1'b0;
        row_ready1 = 1'b1;
        cyc        = 1;
        while (cyc < 20 && !done1) begin
            tests++;
            if (exp_idx > 1) begin
                fails++;
                $display("FAIL n1_extra_row: row %0d offered, only 2 rows exist", row_in1);
                break;
            end
            if (row_valid1 !== 1'b1 || row_in1 !== exp_idx[0:0] || row_out1 !== tbl1[exp_idx]) begin
                fails++;
                $display("FAIL n1_row: valid=%b row=%0d out=%b, required 1 %0d %b",
                         row_valid1, row_in1, row_out1, exp_idx, tbl1[exp_idx]);
            end
            ones_model += int'(tbl1[exp_idx]);
            exp_idx++;
            step();
            cyc++;
        end
        row_ready1 = 1'b0;
        tests++;
        if (cyc != 3 || done1 !== 1'b1) begin
            fails++;
            $display("FAIL n1_done_cycle: done=%b at cycle %0d, required 1 at 3", done1, cyc);
        end
        tests++;
        if (ones1 !== 2'(ones_model) || ones1 !== 2'd1 || row_in1 !== 1'b1) begin
            fails++;
            $display("FAIL n1_ones: ones=%0d idx=%0d, required 1 1", ones1, row_in1);
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_backpressure();
        test_table_load();
        test_ignore_in_sweep();
        test_start_with_load();
        test_random();
        test_reset_mid_sweep();
        test_n1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
